// File: rtl/fp_entry_pkg.sv
// Shared types and constants for the floating-point operand entry front end.
// Build option: DEBOUNCE_EN enables the button debounce counter.
package fp_entry_pkg;

  localparam int NIBBLES = 8;
  localparam int FP_W    = 32;
  localparam int NIB_W   = 4;
  localparam int IDX_W   = 3;

  // Entry FSM states; encodings are visible on the state output for display.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Shift one hex nibble into the low end of an operand, MSB nibble first.
  function automatic logic [FP_W-1:0] shift_in(input logic [FP_W-1:0] v,
                                                input logic [NIB_W-1:0] n);
    return {v[FP_W-NIB_W-1:0], n};
  endfunction

endpackage

// File: rtl/fp_operand_entry_fsm_button_press_pulse.sv
// Turns a raw asynchronous push-button into a single-cycle press pulse:
// 2-flop synchronizer, optional debounce counter, rising-edge detector.
// Build option: DEBOUNCE_EN inserts the debounce counter (DEBOUNCE_CYCLES
// consecutive high samples required); without it DEBOUNCE_CYCLES is unused.
module button_press_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_press;
  logic w_level;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // Count consecutive high samples; any low sample restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!r_sync2) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  // Registered rising-edge detect: a held button yields exactly one pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= w_level & ~r_level_d;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/fp_operand_entry_fsm.sv
// Operand entry front end: collects operand A then B (8 hex nibbles each,
// MSB first) and offers the pair to the adder on a valid/ready handshake.
// Handshake: op_valid is high exactly while in S_SEND and the operands are
// frozen; a transfer happens on a rising edge with op_valid && op_ready, and
// op_valid falls the following cycle. op_ready is ignored elsewhere.
// Build option: DEBOUNCE_EN enables the debounce stage in the press path.
module fp_operand_entry_fsm
  import fp_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [3:0]  nibble,
  input  logic        clear,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  output logic [2:0]  state,
  output logic [2:0]  nib_idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic             w_press;
  state_t           r_state;
  state_t           w_state_next;
  logic [FP_W-1:0]  r_op_a;
  logic [FP_W-1:0]  r_op_b;
  logic [FP_W-1:0]  w_op_a_next;
  logic [FP_W-1:0]  w_op_b_next;
  logic [IDX_W-1:0] r_nib_idx;
  logic [IDX_W-1:0] w_nib_idx_next;

  button_press_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_press (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .press (w_press)
  );

  // State, operand and nibble-index registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_nib_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_op_a    <= w_op_a_next;
      r_op_b    <= w_op_b_next;
      r_nib_idx <= w_nib_idx_next;
    end
  end

  // Next-state and datapath updates; clear overrides everything else.
  always_comb begin
    w_state_next   = r_state;
    w_op_a_next    = r_op_a;
    w_op_b_next    = r_op_b;
    w_nib_idx_next = r_nib_idx;

    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_op_a_next    = shift_in(r_op_a, nibble);
          w_nib_idx_next = IDX_W'(1);
          w_state_next   = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (w_press) begin
          w_op_a_next = shift_in(r_op_a, nibble);
          if (r_nib_idx == IDX_LAST) begin
            w_nib_idx_next = '0;
            w_state_next   = S_LOAD_B;
          end else begin
            w_nib_idx_next = r_nib_idx + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (w_press) begin
          w_op_b_next = shift_in(r_op_b, nibble);
          if (r_nib_idx == IDX_LAST) begin
            w_nib_idx_next = '0;
            w_state_next   = S_SEND;
          end else begin
            w_nib_idx_next = r_nib_idx + 1'b1;
          end
        end
      end
      S_SEND: begin
        // Operands frozen; presses ignored until the consumer takes them.
        if (op_ready) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // A new press starts a fresh operand A and discards the old B.
        if (w_press) begin
          w_op_a_next    = {{(FP_W-NIB_W){1'b0}}, nibble};
          w_op_b_next    = '0;
          w_nib_idx_next = IDX_W'(1);
          w_state_next   = S_LOAD_A;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_op_a_next    = '0;
        w_op_b_next    = '0;
        w_nib_idx_next = '0;
      end
    endcase

    if (clear) begin
      w_state_next   = S_IDLE;
      w_op_a_next    = '0;
      w_op_b_next    = '0;
      w_nib_idx_next = '0;
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_valid = (r_state == S_SEND);
  assign state    = r_state;
  assign nib_idx  = r_nib_idx;

endmodule
